// File: rtl/controlador_display.sv
// controlador_display: converts a signed 8-bit value to sign + two BCD digit codes for a 2-digit display.
// Latency: write accepted at edge N, outputs and pronto=1 visible after edge N+9 (8 double-dabble steps + 1 update).
// Backpressure: pronto=0 while busy; escrita seen while busy is dropped, not queued.
//
// Ports:
//   clock, reset           - single clock, synchronous active-high reset
//   escrita, valor[7:0]    - write strobe and signed value, taken only when pronto=1
//   pronto                 - idle, ready for a new write
//   sinal, dezena, unidade - sign (1 = negative) and tens/units digit codes to the display driver
//   estouro                - value outside -99..+99, both digits show a dash
module controlador_display #(
  parameter int         SUPRIME_ZERO = 1,
  parameter logic [3:0] COD_BRANCO   = 4'hA,
  parameter logic [3:0] COD_TRACO    = 4'hF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       escrita,
  input  logic [7:0] valor,
  output logic       pronto,
  output logic       sinal,
  output logic [3:0] dezena,
  output logic [3:0] unidade,
  output logic       estouro
);

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] CONVERTE = 2'd1;
  localparam logic [1:0] ATUALIZA = 2'd2;

  logic [1:0]  estado;
  logic        negativo;
  logic [7:0]  magnitude;
  logic [11:0] bcd;
  logic [2:0]  contador;

  // Absolute value kept at 8 bits so -128 maps to magnitude 128 (unsigned).
  logic [7:0] valor_abs;
  assign valor_abs = valor[7] ? (~valor + 8'd1) : valor;

  // One double-dabble step: correct every nibble >= 5, then shift {bcd, magnitude} left.
  logic [11:0] bcd_ajustado;
  logic [19:0] deslocado;

  always_comb begin
    bcd_ajustado = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_ajustado[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    deslocado = {bcd_ajustado, magnitude} << 1;
  end

  logic [3:0] centena_bcd, dezena_bcd, unidade_bcd;
  assign centena_bcd = bcd[11:8];
  assign dezena_bcd  = bcd[7:4];
  assign unidade_bcd = bcd[3:0];

  assign pronto = (estado == OCIOSO);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= OCIOSO;
      negativo  <= 1'b0;
      magnitude <= 8'd0;
      bcd       <= 12'd0;
      contador  <= 3'd0;
      sinal     <= 1'b0;
      dezena    <= COD_BRANCO;
      unidade   <= COD_BRANCO;
      estouro   <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (escrita) begin
            negativo  <= valor[7];
            magnitude <= valor_abs;
            bcd       <= 12'd0;
            contador  <= 3'd0;
            estado    <= CONVERTE;
          end
        end

        CONVERTE: begin
          bcd       <= deslocado[19:8];
          magnitude <= deslocado[7:0];
          contador  <= contador + 3'd1;
          if (contador == 3'd7)
            estado <= ATUALIZA;
        end

        ATUALIZA: begin
          if (centena_bcd != 4'd0) begin
            // Magnitude >= 100 cannot be shown on two digits: dashes, no sign.
            sinal   <= 1'b0;
            dezena  <= COD_TRACO;
            unidade <= COD_TRACO;
            estouro <= 1'b1;
          end else begin
            // A negative value always has nonzero magnitude, so zero never shows a sign.
            sinal   <= negativo;
            unidade <= unidade_bcd;
            estouro <= 1'b0;
            if ((dezena_bcd == 4'd0) && (SUPRIME_ZERO != 0))
              dezena <= COD_BRANCO;
            else
              dezena <= dezena_bcd;
          end
          estado <= OCIOSO;
        end

        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_display.sv
// Testbench for controlador_display: directed writes with hand-computed results,
// a scoreboard queue filled by the driver and drained by a monitor on pronto rising.
module tb_controlador_display;

  logic       clk = 1'b0;
  logic       reset;
  logic       escrita;
  logic [7:0] valor;

  logic       pronto0, sinal0, estouro0;
  logic [3:0] dezena0, unidade0;
  logic       pronto1, sinal1, estouro1;
  logic [3:0] dezena1, unidade1;

  always #5 clk = ~clk;

  controlador_display dut0 (
    .clock   (clk),
    .reset   (reset),
    .escrita (escrita),
    .valor   (valor),
    .pronto  (pronto0),
    .sinal   (sinal0),
    .dezena  (dezena0),
    .unidade (unidade0),
    .estouro (estouro0)
  );

  controlador_display #(.SUPRIME_ZERO(0)) dut1 (
    .clock   (clk),
    .reset   (reset),
    .escrita (escrita),
    .valor   (valor),
    .pronto  (pronto1),
    .sinal   (sinal1),
    .dezena  (dezena1),
    .unidade (unidade1),
    .estouro (estouro1)
  );

  typedef struct {
    logic [9:0] out0;     // {sinal, dezena, unidade, estouro}, SUPRIME_ZERO=1
    logic [9:0] out1;     // same, SUPRIME_ZERO=0
    int         issue;    // cycle of the accepting edge
    bit         chk_lat;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_pronto = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] mk(input logic s, input logic [3:0] d, input logic [3:0] u, input logic o);
    return {s, d, u, o};
  endfunction

  // Monitor: every 0->1 transition of pronto is an output event to be checked.
  always @(negedge clk) begin
    if (pronto0 === 1'b1 && prev_pronto !== 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: got %h, required no update", {sinal0, dezena0, unidade0, estouro0});
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({sinal0, dezena0, unidade0, estouro0} !== e.out0) begin
          errors++;
          $display("FAIL %s_sz1: got %h required %h", e.name, {sinal0, dezena0, unidade0, estouro0}, e.out0);
        end
        checks++;
        if ({pronto1, sinal1, dezena1, unidade1, estouro1} !== {1'b1, e.out1}) begin
          errors++;
          $display("FAIL %s_sz0: got %h required %h", e.name, {pronto1, sinal1, dezena1, unidade1, estouro1}, {1'b1, e.out1});
        end
        if (e.chk_lat) begin
          checks++;
          if (cyc - e.issue != 9) begin
            errors++;
            $display("FAIL %s_latency: got %0d required 9", e.name, cyc - e.issue);
          end
        end
      end
    end
    prev_pronto = pronto0;
  end

  task automatic push(input logic [9:0] e0, input logic [9:0] e1, input bit lat, input string nm);
    exp_t e;
    e.out0 = e0; e.out1 = e1; e.issue = cyc; e.chk_lat = lat; e.name = nm;
    q.push_back(e);
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (pronto0 === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: pronto got %b required 1 within 50 cycles", pronto0);
    end
  endtask

  // Write a value; valor is scrambled after acceptance so a design that
  // reads valor during conversion gets a wrong answer.
  task automatic do_write(input logic [7:0] v, input logic [9:0] e0, input logic [9:0] e1, input string nm);
    wait_ready();
    escrita = 1'b1;
    valor   = v;
    @(posedge clk);
    #1;
    push(e0, e1, 1'b1, nm);
    escrita = 1'b0;
    valor   = ~v;
  endtask

  initial begin
    reset   = 1'b1;
    escrita = 1'b1;   // reset must win over a write on the same edge
    valor   = 8'd33;
    @(posedge clk);
    #1;
    push(mk(0, 4'hA, 4'hA, 0), mk(0, 4'hA, 4'hA, 0), 1'b0, "reset");
    @(negedge clk);
    reset   = 1'b0;
    escrita = 1'b0;

    do_write(8'd47,  mk(0, 4'h4, 4'h7, 0), mk(0, 4'h4, 4'h7, 0), "p47");
    do_write(8'hFB,  mk(1, 4'hA, 4'h5, 0), mk(1, 4'h0, 4'h5, 0), "m5");
    do_write(8'd99,  mk(0, 4'h9, 4'h9, 0), mk(0, 4'h9, 4'h9, 0), "p99");
    do_write(8'h9D,  mk(1, 4'h9, 4'h9, 0), mk(1, 4'h9, 4'h9, 0), "m99");
    do_write(8'd100, mk(0, 4'hF, 4'hF, 1), mk(0, 4'hF, 4'hF, 1), "p100");
    do_write(8'h80,  mk(0, 4'hF, 4'hF, 1), mk(0, 4'hF, 4'hF, 1), "m128");
    do_write(8'd0,   mk(0, 4'hA, 4'h0, 0), mk(0, 4'h0, 4'h0, 0), "zero");
    do_write(8'hFF,  mk(1, 4'hA, 4'h1, 0), mk(1, 4'h0, 4'h1, 0), "m1");
    do_write(8'd127, mk(0, 4'hF, 4'hF, 1), mk(0, 4'hF, 4'hF, 1), "p127");
    do_write(8'h9C,  mk(0, 4'hF, 4'hF, 1), mk(0, 4'hF, 4'hF, 1), "m100");
    do_write(8'd10,  mk(0, 4'h1, 4'h0, 0), mk(0, 4'h1, 4'h0, 0), "p10");

    // Write 12, then a single-cycle pulse with 34 at N+3 must be dropped.
    do_write(8'd12, mk(0, 4'h1, 4'h2, 0), mk(0, 4'h1, 4'h2, 0), "pulse12");
    repeat (2) @(posedge clk);
    @(negedge clk);
    escrita = 1'b1;
    valor   = 8'd34;
    @(posedge clk);
    #1;
    escrita = 1'b0;

    // Write 12 with escrita held: 34 is taken on edge N+10.
    wait_ready();
    escrita = 1'b1;
    valor   = 8'd12;
    @(posedge clk);
    #1;
    push(mk(0, 4'h1, 4'h2, 0), mk(0, 4'h1, 4'h2, 0), 1'b1, "hold12");
    valor = 8'd34;
    repeat (10) @(posedge clk);
    #1;
    push(mk(0, 4'h3, 4'h4, 0), mk(0, 4'h3, 4'h4, 0), 1'b1, "hold34");
    escrita = 1'b0;

    // Write 56, reset at N+4: conversion aborted, outputs blank, no later update.
    wait_ready();
    escrita = 1'b1;
    valor   = 8'd56;
    @(posedge clk);
    #1;
    escrita = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    push(mk(0, 4'hA, 4'hA, 0), mk(0, 4'hA, 4'hA, 0), 1'b0, "abort56");
    @(negedge clk);
    reset = 1'b0;

    repeat (30) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
